// File: rtl/fetch_target_queue_pkg.sv
// Fetch Target Queue shared definitions.
// Holds the default geometry of the queue (depth, address width, fetch-block
// size), the derived index/pointer widths and the two-state controller
// encoding used by fetch_target_queue and ftq_entry_regfile.
package fetch_target_queue_pkg;

    localparam int FtqDepth   = 8;
    localparam int FtqAddrW   = 32;
    localparam int FetchBytes = 16;
    localparam int FtqIdxBus  = $clog2(FtqDepth);
    localparam int FtqPtrBus  = FtqIdxBus + 1;

    typedef enum logic {
        FtqRun   = 1'b0,
        FtqRedir = 1'b1
    } ftqState_e;

endpackage

// File: rtl/ftq_entry_regfile.sv
// FTQ entry storage: DEPTH x {Pc, Taken, Target}.
// Ports:
//   Clk                                   rising-edge clock (storage is not reset)
//   enqWe/enqIdx/enqPc/enqTaken/enqTarget enqueue write port
//   resWe/resIdx/resTaken/resTarget       resolve-update write port (Pc untouched)
//   fetchIdx -> fetchPc                   async read port for the fetch side
//   resIdx -> resPc/resTakenRd/resTargetRd async read port for the resolve side
module ftq_entry_regfile
    import fetch_target_queue_pkg::*;
#(
    parameter int  DEPTH  = FtqDepth,
    parameter int  ADDR_W = FtqAddrW,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              enqWe,
    input  logic [IDX_W-1:0]  enqIdx,
    input  logic [ADDR_W-1:0] enqPc,
    input  logic              enqTaken,
    input  logic [ADDR_W-1:0] enqTarget,
    input  logic              resWe,
    input  logic [IDX_W-1:0]  resIdx,
    input  logic              resTaken,
    input  logic [ADDR_W-1:0] resTarget,
    input  logic [IDX_W-1:0]  fetchIdx,
    output logic [ADDR_W-1:0] fetchPc,
    output logic [ADDR_W-1:0] resPc,
    output logic              resTakenRd,
    output logic [ADDR_W-1:0] resTargetRd
);

    logic [ADDR_W-1:0] pcMem     [DEPTH];
    logic              takenMem  [DEPTH];
    logic [ADDR_W-1:0] targetMem [DEPTH];

    always_ff @(posedge Clk) begin
        if (enqWe) begin
            pcMem[enqIdx]     <= enqPc;
            takenMem[enqIdx]  <= enqTaken;
            targetMem[enqIdx] <= enqTarget;
        end
        // Placed last so the resolve update wins on a same-index collision.
        if (resWe) begin
            takenMem[resIdx]  <= resTaken;
            targetMem[resIdx] <= resTarget;
        end
    end

    assign fetchPc     = pcMem[fetchIdx];
    assign resPc       = pcMem[resIdx];
    assign resTakenRd  = takenMem[resIdx];
    assign resTargetRd = targetMem[resIdx];

endmodule

// File: rtl/fetch_target_queue.sv
// Fetch Target Queue between the BPU and the ICache/backend.
// Buffers predicted fetch blocks, hands them to the ICache in order, checks
// backend resolutions against the stored prediction and on a mispredict
// raises a one-cycle redirect back to the PC-generation stage.
// Ports:
//   Clk, Rest                      clock, asynchronous active-low reset
//   BpuValid/BpuPc/BpuTarget/BpuTaken, BpuReady   enqueue handshake
//   FetchValid/FetchPc/FetchIdx, IfuReady          fetch handshake
//   ResolveValid/ResolveIdx/ResolveTaken/ResolveTarget  backend resolution
//   CommitValid                    retire oldest fetched entry
//   ReDirectAble/ReDirEctPc        redirect pulse and PC
//   FtqFull                        occupancy == DEPTH
// Optional: define FTQ_PERF_EN to add PerfMispredCnt and PerfFullCnt
// (saturating 32-bit counters).
module fetch_target_queue
    import fetch_target_queue_pkg::*;
#(
    parameter int  DEPTH       = FtqDepth,
    parameter int  ADDR_W      = FtqAddrW,
    parameter int  FETCH_BYTES = FetchBytes,
    localparam int IDX_W       = $clog2(DEPTH),
    localparam int PTR_W       = IDX_W + 1
) (
    input  logic              Clk,
    input  logic              Rest,
    input  logic              BpuValid,
    input  logic [ADDR_W-1:0] BpuPc,
    input  logic [ADDR_W-1:0] BpuTarget,
    input  logic              BpuTaken,
    output logic              BpuReady,
    output logic              FetchValid,
    output logic [ADDR_W-1:0] FetchPc,
    output logic [IDX_W-1:0]  FetchIdx,
    input  logic              IfuReady,
    input  logic              ResolveValid,
    input  logic [IDX_W-1:0]  ResolveIdx,
    input  logic              ResolveTaken,
    input  logic [ADDR_W-1:0] ResolveTarget,
    input  logic              CommitValid,
    output logic              ReDirectAble,
    output logic [ADDR_W-1:0] ReDirEctPc,
    output logic              FtqFull
`ifdef FTQ_PERF_EN
   ,output logic [31:0]       PerfMispredCnt,
    output logic [31:0]       PerfFullCnt
`endif
);

    logic [PTR_W-1:0]  enqPtr;
    logic [PTR_W-1:0]  fetchPtr;
    logic [PTR_W-1:0]  commitPtr;
    ftqState_e         state;
    logic [ADDR_W-1:0] redirPc;

    logic [PTR_W-1:0]  occupancy;
    logic [IDX_W-1:0]  resOffset;
    logic [PTR_W-1:0]  resPtr;
    logic [PTR_W-1:0]  redirPtr;
    logic              resolveLive;
    logic              mispredict;
    logic              enqFire;
    logic              fetchFire;
    logic              commitFire;
    logic [ADDR_W-1:0] fetchRdPc;
    logic [ADDR_W-1:0] resRdPc;
    logic              resRdTaken;
    logic [ADDR_W-1:0] resRdTarget;
    logic [ADDR_W-1:0] resWrTarget;

    assign occupancy    = enqPtr - commitPtr;
    assign FtqFull      = (occupancy == PTR_W'(DEPTH));
    assign BpuReady     = (state == FtqRun) && !FtqFull;
    assign FetchValid   = (state == FtqRun) && (fetchPtr != enqPtr);
    assign FetchIdx     = fetchPtr[IDX_W-1:0];
    // Storage is not reset, so the PC is masked whenever nothing is valid.
    assign FetchPc      = FetchValid ? fetchRdPc : '0;
    assign ReDirectAble = (state == FtqRedir);
    assign ReDirEctPc   = redirPc;

    // A resolve is live when its distance from Commit (mod DEPTH) is below
    // the occupancy; that distance also rebuilds the entry's full pointer,
    // so the wrap bit comes out in the same frame as Enq.
    assign resOffset   = ResolveIdx - commitPtr[IDX_W-1:0];
    assign resolveLive = ResolveValid && ({1'b0, resOffset} < occupancy);
    assign resPtr      = commitPtr + {1'b0, resOffset};
    assign redirPtr    = resPtr + PTR_W'(1);

    assign mispredict  = resolveLive &&
                         ((ResolveTaken != resRdTaken) ||
                          (ResolveTaken && (ResolveTarget != resRdTarget)));
    // A not-taken outcome keeps the old target so a correct resolve is a no-op.
    assign resWrTarget = ResolveTaken ? ResolveTarget : resRdTarget;

    // Enqueue on a mispredict cycle is on the wrong path and is dropped.
    assign enqFire     = BpuValid && BpuReady && !mispredict;
    assign fetchFire   = FetchValid && IfuReady;
    assign commitFire  = CommitValid && (commitPtr != fetchPtr);

    ftq_entry_regfile #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) uRegfile (
        .Clk         (Clk),
        .enqWe       (enqFire),
        .enqIdx      (enqPtr[IDX_W-1:0]),
        .enqPc       (BpuPc),
        .enqTaken    (BpuTaken),
        .enqTarget   (BpuTarget),
        .resWe       (resolveLive),
        .resIdx      (ResolveIdx),
        .resTaken    (ResolveTaken),
        .resTarget   (resWrTarget),
        .fetchIdx    (fetchPtr[IDX_W-1:0]),
        .fetchPc     (fetchRdPc),
        .resPc       (resRdPc),
        .resTakenRd  (resRdTaken),
        .resTargetRd (resRdTarget)
    );

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state     <= FtqRun;
            enqPtr    <= '0;
            fetchPtr  <= '0;
            commitPtr <= '0;
            redirPc   <= '0;
        end else begin
            if (mispredict) begin
                state    <= FtqRedir;
                enqPtr   <= redirPtr;
                fetchPtr <= redirPtr;
                redirPc  <= ResolveTaken ? ResolveTarget
                                         : resRdPc + ADDR_W'(FETCH_BYTES);
            end else begin
                state <= FtqRun;
                if (enqFire) begin
                    enqPtr <= enqPtr + PTR_W'(1);
                end
                if (fetchFire) begin
                    fetchPtr <= fetchPtr + PTR_W'(1);
                end
            end
            if (commitFire) begin
                commitPtr <= commitPtr + PTR_W'(1);
            end
        end
    end

`ifdef FTQ_PERF_EN
    function automatic logic [31:0] satInc(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            PerfMispredCnt <= '0;
            PerfFullCnt    <= '0;
        end else begin
            PerfMispredCnt <= satInc(PerfMispredCnt, mispredict);
            PerfFullCnt    <= satInc(PerfFullCnt, BpuValid && FtqFull);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_target_queue.sv
module tb_fetch_target_queue;

    localparam int DEPTH = 8;

    logic        Clk;
    logic        Rest;
    logic        BpuValid;
    logic [31:0] BpuPc;
    logic [31:0] BpuTarget;
    logic        BpuTaken;
    logic        BpuReady;
    logic        FetchValid;
    logic [31:0] FetchPc;
    logic [2:0]  FetchIdx;
    logic        IfuReady;
    logic        ResolveValid;
    logic [2:0]  ResolveIdx;
    logic        ResolveTaken;
    logic [31:0] ResolveTarget;
    logic        CommitValid;
    logic        ReDirectAble;
    logic [31:0] ReDirEctPc;
    logic        FtqFull;
`ifdef FTQ_PERF_EN
    logic [31:0] PerfMispredCnt;
    logic [31:0] PerfFullCnt;
`endif

    int checks = 0;
    int errors = 0;

    fetch_target_queue #(
        .DEPTH       (8),
        .ADDR_W      (32),
        .FETCH_BYTES (16)
    ) dut (
        .Clk           (Clk),
        .Rest          (Rest),
        .BpuValid      (BpuValid),
        .BpuPc         (BpuPc),
        .BpuTarget     (BpuTarget),
        .BpuTaken      (BpuTaken),
        .BpuReady      (BpuReady),
        .FetchValid    (FetchValid),
        .FetchPc       (FetchPc),
        .FetchIdx      (FetchIdx),
        .IfuReady      (IfuReady),
        .ResolveValid  (ResolveValid),
        .ResolveIdx    (ResolveIdx),
        .ResolveTaken  (ResolveTaken),
        .ResolveTarget (ResolveTarget),
        .CommitValid   (CommitValid),
        .ReDirectAble  (ReDirectAble),
        .ReDirEctPc    (ReDirEctPc),
        .FtqFull       (FtqFull)
`ifdef FTQ_PERF_EN
       ,.PerfMispredCnt (PerfMispredCnt),
        .PerfFullCnt    (PerfFullCnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (actual=running required=finished)");
        $fatal(1);
    end

    // Reference model: unbounded sequence counters over a circular store.
    int          mEnq, mFetch, mCommit;
    bit          mRedir;
    logic [31:0] mRedirPc;
    logic [31:0] mPc  [DEPTH];
    logic [31:0] mTgt [DEPTH];
    bit          mTaken [DEPTH];
    int          mMisCnt, mFullCnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mEnq = 0; mFetch = 0; mCommit = 0;
        mRedir = 1'b0; mRedirPc = 32'h0;
        mMisCnt = 0; mFullCnt = 0;
    endtask

    task automatic checkOutputs();
        int occ;
        bit expFv;
        occ   = mEnq - mCommit;
        expFv = !mRedir && (mFetch < mEnq);
        chk("BpuReady",     32'(BpuReady),     32'(!mRedir && (occ < DEPTH)));
        chk("FetchValid",   32'(FetchValid),   32'(expFv));
        chk("FetchPc",      FetchPc,           expFv ? mPc[mFetch % DEPTH] : 32'h0);
        chk("FetchIdx",     32'(FetchIdx),     32'(mFetch % DEPTH));
        chk("FtqFull",      32'(FtqFull),      32'(occ == DEPTH));
        chk("ReDirectAble", 32'(ReDirectAble), 32'(mRedir));
        chk("ReDirEctPc",   ReDirEctPc,        mRedirPc);
`ifdef FTQ_PERF_EN
        chk("PerfMispredCnt", PerfMispredCnt, 32'(mMisCnt));
        chk("PerfFullCnt",    PerfFullCnt,    32'(mFullCnt));
`endif
    endtask

    // Called at a falling edge: drive inputs, check, advance model, return at next falling edge.
    task automatic cycle(input bit bv, input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                         input bit ifu, input bit rv, input logic [2:0] ridx, input bit rtk,
                         input logic [31:0] rtgt, input bit cv);
        int occ, k, fOld;
        bit rdy, fv, live, mis;
        BpuValid = bv; BpuPc = pc; BpuTaken = tk; BpuTarget = tgt; IfuReady = ifu;
        ResolveValid = rv; ResolveIdx = ridx; ResolveTaken = rtk; ResolveTarget = rtgt;
        CommitValid = cv;
        #1;
        checkOutputs();
        occ  = mEnq - mCommit;
        rdy  = !mRedir && (occ < DEPTH);
        fv   = !mRedir && (mFetch < mEnq);
        fOld = mFetch;
        live = 1'b0; k = 0;
        if (rv) begin
            for (int j = mCommit; j < mEnq; j++) begin
                if ((j % DEPTH) == int'(ridx)) begin live = 1'b1; k = j; end
            end
        end
        mis = live && ((rtk != mTaken[ridx]) || (rtk && (rtgt != mTgt[ridx])));
        if (mis) mMisCnt++;
        if (bv && (occ == DEPTH)) mFullCnt++;
        if (mis) begin
            mRedirPc = rtk ? rtgt : mPc[ridx] + 32'd16;
            mEnq = k + 1; mFetch = k + 1; mRedir = 1'b1;
        end else begin
            mRedir = 1'b0;
            if (bv && rdy) begin
                mPc[mEnq % DEPTH] = pc; mTaken[mEnq % DEPTH] = tk; mTgt[mEnq % DEPTH] = tgt;
                mEnq++;
            end
            if (fv && ifu) mFetch++;
        end
        if (live) begin mTaken[ridx] = rtk; mTgt[ridx] = rtgt; end
        if (cv && (mCommit != fOld)) mCommit++;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic enq(input logic [31:0] pc, input bit tk, input logic [31:0] tgt, input bit ifu);
        cycle(1'b1, pc, tk, tgt, ifu, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic idle(input bit ifu, input bit cv);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, ifu, 1'b0, 3'd0, 1'b0, 32'h0, cv);
    endtask

    task automatic resolve(input logic [2:0] idx, input bit rtk, input logic [31:0] rtgt,
                           input bit bv, input logic [31:0] pc, input bit ifu);
        cycle(bv, pc, 1'b0, 32'h0, ifu, 1'b1, idx, rtk, rtgt, 1'b0);
    endtask

    task automatic doReset();
        Rest = 1'b0;
        BpuValid = 0; BpuPc = 0; BpuTarget = 0; BpuTaken = 0; IfuReady = 0;
        ResolveValid = 0; ResolveIdx = 0; ResolveTaken = 0; ResolveTarget = 0; CommitValid = 0;
        modelReset();
        #1;
        checkOutputs();
        @(posedge Clk);
        @(negedge Clk);
        Rest = 1'b1;
    endtask

    typedef struct {
        bit          bv;
        logic [31:0] pc;
        bit          ifu;
        bit          expFv;
        logic [31:0] expPc;
        bit          expRdy;
    } vec_t;

    initial begin
        vec_t        tbl [5];
        bit          bv, tk, ifu, rv, rtk, cv;
        logic [31:0] pc, tgt, rtgt;
        logic [2:0]  ridx;
        int          occ;

        tbl[0] = '{1'b1, 32'h1000, 1'b1, 1'b0, 32'h0,    1'b1};
        tbl[1] = '{1'b1, 32'h1010, 1'b1, 1'b1, 32'h1000, 1'b1};
        tbl[2] = '{1'b1, 32'h1020, 1'b1, 1'b1, 32'h1010, 1'b1};
        tbl[3] = '{1'b0, 32'h0,    1'b1, 1'b1, 32'h1020, 1'b1};
        tbl[4] = '{1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    1'b1};

        Rest = 1'b1;
        BpuValid = 0; BpuPc = 0; BpuTarget = 0; BpuTaken = 0; IfuReady = 0;
        ResolveValid = 0; ResolveIdx = 0; ResolveTaken = 0; ResolveTarget = 0; CommitValid = 0;
        #2;
        doReset();

        // In-order fetch of three not-taken blocks.
        for (int i = 0; i < 5; i++) begin
            chk("tblFetchValid", 32'(FetchValid), 32'(tbl[i].expFv));
            chk("tblFetchPc",    FetchPc,         tbl[i].expPc);
            chk("tblBpuReady",   32'(BpuReady),   32'(tbl[i].expRdy));
            cycle(tbl[i].bv, tbl[i].pc, 1'b0, 32'h0, tbl[i].ifu, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0);
        end

        // Fill to DEPTH, commit blocked until something is fetched.
        doReset();
        for (int i = 0; i < 8; i++) enq(32'h8000 + 32'(i * 16), 1'b0, 32'h0, 1'b0);
        chk("fullFtqFull",  32'(FtqFull),  32'd1);
        chk("fullBpuReady", 32'(BpuReady), 32'd0);
        idle(1'b0, 1'b1);
        chk("unfetchedCommitFull", 32'(FtqFull), 32'd1);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b1);
        chk("afterCommitFull",  32'(FtqFull),  32'd0);
        chk("afterCommitReady", 32'(BpuReady), 32'd1);

        // Not-taken entry at idx 2 resolved taken.
        doReset();
        enq(32'h1E00, 1'b0, 32'h0, 1'b0);
        enq(32'h1F00, 1'b0, 32'h0, 1'b0);
        enq(32'h2000, 1'b0, 32'h0, 1'b0);
        resolve(3'd2, 1'b1, 32'h3000, 1'b0, 32'h0, 1'b0);
        chk("redirAble",     32'(ReDirectAble), 32'd1);
        chk("redirPc",       ReDirEctPc,        32'h3000);
        chk("redirReady",    32'(BpuReady),     32'd0);
        chk("redirFetchIdx", 32'(FetchIdx),     32'd3);
        idle(1'b0, 1'b0);
        chk("postRedirAble",  32'(ReDirectAble), 32'd0);
        chk("postRedirReady", 32'(BpuReady),     32'd1);
        chk("postRedirEmpty", 32'(FetchValid),   32'd0);
        enq(32'h6000, 1'b0, 32'h0, 1'b0);
        chk("refillValid", 32'(FetchValid), 32'd1);
        chk("refillPc",    FetchPc,         32'h6000);
        chk("refillIdx",   32'(FetchIdx),   32'd3);

        // Taken entry resolved not-taken, with a simultaneous enqueue.
        doReset();
        enq(32'h4000, 1'b1, 32'h5000, 1'b1);
        idle(1'b1, 1'b0);
        resolve(3'd0, 1'b0, 32'h0, 1'b1, 32'h9000, 1'b1);
        chk("ntRedirAble", 32'(ReDirectAble), 32'd1);
        chk("ntRedirPc",   ReDirEctPc,        32'h4010);
        idle(1'b1, 1'b0);
        chk("droppedEnqValid", 32'(FetchValid), 32'd0);
        chk("droppedEnqIdx",   32'(FetchIdx),   32'd1);

        // Out-of-window resolve, then a correct one: neither redirects.
        resolve(3'd5, 1'b1, 32'h7777, 1'b0, 32'h0, 1'b0);
        chk("oorNoRedir",  32'(ReDirectAble), 32'd0);
        chk("oorFetchIdx", 32'(FetchIdx),     32'd1);
        resolve(3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("correctNoRedir", 32'(ReDirectAble), 32'd0);

        // Reset in the middle of a redirect cycle.
        resolve(3'd0, 1'b1, 32'hA000, 1'b0, 32'h0, 1'b0);
        chk("preResetRedir", 32'(ReDirectAble), 32'd1);
        doReset();
        chk("rstRedirAble", 32'(ReDirectAble), 32'd0);
        chk("rstRedirPc",   ReDirEctPc,        32'd0);
        chk("rstBpuReady",  32'(BpuReady),     32'd1);

`ifdef FTQ_PERF_EN
        doReset();
        for (int i = 0; i < 8; i++) enq(32'h100 + 32'(i * 16), 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) enq(32'hDEAD0, 1'b0, 32'h0, 1'b0);
        chk("perfFullCnt", PerfFullCnt, 32'd5);
        resolve(3'd0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        resolve(3'd0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0);
        resolve(3'd0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
        chk("perfMispredCnt", PerfMispredCnt, 32'd3);
        chk("perfFullHold",   PerfFullCnt,    32'd5);
`endif

        // Randomized traffic against the model.
        doReset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset();
            end else begin
                bv  = ($urandom_range(0, 9) < 7);
                tk  = $urandom_range(0, 1) == 1;
                pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFF0);
                tgt = 32'h100 * $urandom_range(0, 7);
                ifu = ($urandom_range(0, 9) < 6);
                rv  = ($urandom_range(0, 9) < 2);
                cv  = ($urandom_range(0, 9) < 4);
                occ = mEnq - mCommit;
                if ((occ > 0) && ($urandom_range(0, 3) != 0))
                    ridx = 3'((mCommit + int'($urandom_range(0, occ - 1))) % DEPTH);
                else
                    ridx = 3'($urandom_range(0, 7));
                rtk  = $urandom_range(0, 1) == 1;
                rtgt = (rtk && $urandom_range(0, 1) == 1) ? mTgt[ridx] : 32'h100 * $urandom_range(0, 7);
                cycle(bv, pc, tk, tgt, ifu, rv, ridx, rtk, rtgt, cv);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_target_queue.md
# fetch_target_queue

Fetch Target Queue (FTQ) between the BPU and the backend. It buffers predicted fetch blocks produced at the BPU's PC stage and hands them to the ICache in order. It tracks backend branch resolution against each stored prediction, and on a misprediction drives the one-cycle redirect (ReDirectAble / ReDirEctPc) back into the PC-generation stage.

## Interface
- DEPTH, 8: entries; power of two, ≥4
- ADDR_W, 32: address width (matches `InstAddrBus`)
- FETCH_BYTES, 16: fetch-block size; not-taken fall-through = Pc + FETCH_BYTES
- Clk  in  1  clock, rising edge
- Rest  in  1  asynchronous, active-low reset
- BpuValid  in  1  predicted block offered
- BpuPc / BpuTarget  in  ADDR_W  block start PC / predicted target
- BpuTaken  in  1  predicted taken
- BpuReady  out  1  enqueue accepted when BpuValid & BpuReady
- FetchValid  out  1  entry available for ICache
- FetchPc  out  ADDR_W  start PC of oldest unfetched entry
- FetchIdx  out  log2(DEPTH)  its FTQ index
- IfuReady  in  1  ICache consumes when FetchValid & IfuReady
- ResolveValid  in  1  backend resolved a block
- ResolveIdx  in  log2(DEPTH)  resolved entry
- ResolveTaken / ResolveTarget  in  1 / ADDR_W  actual outcome
- CommitValid  in  1  retire oldest entry
- ReDirectAble  out  1  redirect pulse to PC stage
- ReDirEctPc  out  ADDR_W  redirect PC
- FtqFull  out  1  occupancy == DEPTH

## Operation
- Entry: {Pc, Taken, Target}. Storage is not reset; the pointers define validity.
- Three pointers, log2(DEPTH)+1 bits, MSB = wrap bit:
  - Enq, Fetch, Commit, with the invariant Commit ≤ Fetch ≤ Enq (modular).
- Full: Enq−Commit == DEPTH. Fetch-empty: Fetch == Enq.
- States:
  - RUN: BpuReady = !FtqFull.
  - REDIR: lasts 1 cycle; BpuReady = 0, FetchValid = 0, ReDirectAble = 1.
  - REDIR always returns to RUN.
- Resolve is live only if ResolveIdx lies in [Commit, Enq); otherwise it is ignored.
- Mispredict when ResolveTaken ≠ Taken, or when both are taken and ResolveTarget ≠ Target. On mispredict:
  - Entry is overwritten with the actual outcome.
  - Enq and Fetch are set to ResolveIdx+1, with the wrap bit taken from Enq's frame.
  - ReDirEctPc is registered as ResolveTaken ? ResolveTarget : Pc+FETCH_BYTES (modulo 2^ADDR_W).
  - State goes to REDIR.
- A correct resolve only updates the entry (no-op content-wise).
- CommitValid with Commit == Fetch is ignored (an unfetched entry is never retired).
- Simultaneous events:
  - Mispredict + enqueue: the enqueue is dropped (wrong path).
  - Mispredict + fetch handshake: Fetch takes the mispredict value.
  - Commit + anything: Commit still advances.
  - Resolve while in REDIR: processed normally; it may re-enter REDIR and the last one wins.

## Timing
- Enqueue at edge E: FetchValid can rise in the cycle after E (no same-cycle bypass).
- FetchPc/FetchIdx are combinational from storage at Fetch.
- Resolve sampled at edge N:
  - ReDirectAble is high for exactly cycle N+1.
  - BpuReady is low in N+1 and returns in N+2 if the queue is not full.
- Reset (asserted at any time, including mid-REDIR) → RUN, all pointers 0. Outputs under reset:
  - ReDirectAble = 0, ReDirEctPc = 0
  - FetchValid = 0, FetchPc = 0, FetchIdx = 0
  - FtqFull = 0, BpuReady = 1

## Configuration
- `FTQ_PERF_EN` defined adds two outputs, both reset to 0 and saturating at all-ones:
  - PerfMispredCnt (32): counts mispredicts.
  - PerfFullCnt (32): counts cycles with BpuValid & FtqFull.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Add to `define.v`: `FtqDepth`, `FtqIdxBus`, `FtqPtrBus`, `FetchBytes`, and the state encodings `FtqRun`/`FtqRedir`.
- Sub-module `ftq_entry_regfile` holds the DEPTH×{Pc, Taken, Target} storage:
  - 1 enqueue write port plus 1 resolve-update write port; resolve wins when both target the same index.
  - 2 async read ports, for fetch and for resolve.

## Test plan
- Reset, enqueue 0x1000/0x1010/0x1020 not-taken, IfuReady=1 → FetchPc 0x1000, 0x1010, 0x1020 on consecutive cycles, then FetchValid=0.
- Enqueue 8 without commit → FtqFull=1 and BpuReady=0. One CommitValid (after fetch) → FtqFull=0 next cycle.
- Entry idx 2 {Pc 0x2000, not-taken}; resolve idx 2 taken→0x3000 → ReDirectAble for 1 cycle with ReDirEctPc 0x3000, then Enq=Fetch=3.
- Entry {0x4000, taken→0x5000}; resolve not-taken → ReDirEctPc 0x4010. A simultaneous BpuValid enqueue is dropped.
- Resolve idx outside [Commit, Enq) → no redirect, pointers unchanged. Reset asserted during REDIR → all outputs at reset values immediately.
- With `FTQ_PERF_EN`: 3 mispredicts → PerfMispredCnt=3; 5 cycles of BpuValid while full → PerfFullCnt=5.
